adv7123_vga_timing: RTL and testbench

Raster timing generator that sits directly upstream of the ADV7123 pixel-output stage in the VGA_ADV7123 design. It issues per-pixel fetch requests (x, y) to the pixel source. It also produces the HSYNC, VSYNC, BLANK and SYNC strobes, delayed by a configurable pipeline latency so they line up with the returning pixel data at the DAC interface. All timing is parameterised; defaults give 640x480 @ 60 Hz with a 25.175 MHz pixel clock.

---
 rtl/adv7123_vga_pkg.sv | 58 +++++
 rtl/vga_sync_delay.sv | 36 +++
 rtl/adv7123_vga_timing.sv | 123 ++++++++++++
 tb/tb_adv7123_vga_timing.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adv7123_vga_pkg.sv
// Shared timing constants, segment encoding and helpers for the ADV7123 raster timing generator.
// Defaults describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package adv7123_vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_PIX_LAT  = 2;

   localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_H_BACK_START = DEF_H_SYNC_START + DEF_H_SYNC;
   localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_V_BACK_START = DEF_V_SYNC_START + DEF_V_SYNC;

   typedef enum logic [1:0] {
      SEG_ACTIVE,
      SEG_FRONT,
      SEG_SYNC,
      SEG_BACK
   } seg_t;

   // Strobes that travel together through the latency-matching delay line.
   typedef struct packed {
      logic fs;
      logic ls;
      logic vs;
      logic hs;
      logic de;
   } strobe_t;

   function automatic int cnt_w(input int h_total, input int v_total);
      return $clog2((h_total > v_total) ? h_total : v_total);
   endfunction

   function automatic seg_t seg_decode(input int cnt, input int active, input int fp,
                                       input int sync);
      seg_t seg;
      if (cnt < active)
         seg = SEG_ACTIVE;
      else if (cnt < active + fp)
         seg = SEG_FRONT;
      else if (cnt < active + fp + sync)
         seg = SEG_SYNC;
      else
         seg = SEG_BACK;
      return seg;
   endfunction

   localparam int DEF_CNT_W = cnt_w(DEF_H_TOTAL, DEF_V_TOTAL);

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH x WIDTH shift register with enable and async reset to RST_VAL; DEPTH=0 is a wire.
// Latency DEPTH enabled cycles; en=0 freezes every stage.
module vga_sync_delay #(
   parameter int               DEPTH   = 2,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++)
                  stage[i] <= RST_VAL;
            end else if (en) begin
               stage[0] <= d;
               for (int i = 1; i < DEPTH; i++)
                  stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/adv7123_vga_timing.sv
// Raster timing for the ADV7123: registered pixel fetch requests plus syncs/blank delayed PIX_LAT cycles.
// en=0 stalls everything; define ADV7123_SYNC_ON_GREEN_EN to drive composite sync on sync_n.
module adv7123_vga_timing
   import adv7123_vga_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int PIX_LAT   = DEF_PIX_LAT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   output logic                        pix_req,
   output logic [$clog2(H_ACTIVE)-1:0] pix_x,
   output logic [$clog2(V_ACTIVE)-1:0] pix_y,
   output logic                        de,
   output logic                        blank_n,
   output logic                        sync_n,
   output logic                        hsync,
   output logic                        vsync,
   output logic                        line_start,
   output logic                        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CNT_W   = cnt_w(H_TOTAL, V_TOTAL);
   localparam int PX_W    = $clog2(H_ACTIVE);
   localparam int PY_W    = $clog2(V_ACTIVE);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   localparam strobe_t STROBE_IDLE = '{fs: 1'b0, ls: 1'b0, vs: ~VSYNC_POL, hs: ~HSYNC_POL, de: 1'b0};

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   seg_t             h_seg;
   seg_t             v_seg;
   logic             act;
   strobe_t          raw_d;
   strobe_t          raw_q;
   strobe_t          dly;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
         end else begin
            h_cnt <= h_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      h_seg = seg_decode(int'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
      v_seg = seg_decode(int'(v_cnt), V_ACTIVE, V_FP, V_SYNC);
      act   = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);

      raw_d    = STROBE_IDLE;
      raw_d.de = act;
      raw_d.hs = (h_seg == SEG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      raw_d.vs = (v_seg == SEG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      raw_d.ls = act && (h_cnt == '0);
      raw_d.fs = act && (h_cnt == '0) && (v_cnt == '0);
   end

   // Request stage: strobes are registered alongside pix_req so PIX_LAT counts from the request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_req <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
         raw_q   <= STROBE_IDLE;
      end else if (en) begin
         pix_req <= act;
         raw_q   <= raw_d;
         if (act) begin
            pix_x <= h_cnt[PX_W-1:0];
            pix_y <= v_cnt[PY_W-1:0];
         end
      end
   end

   vga_sync_delay #(
      .DEPTH   (PIX_LAT),
      .WIDTH   ($bits(strobe_t)),
      .RST_VAL (STROBE_IDLE)
   ) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (raw_q),
      .q   (dly)
   );

   assign de          = dly.de;
   assign blank_n     = dly.de;
   assign hsync       = dly.hs;
   assign vsync       = dly.vs;
   assign line_start  = dly.ls;
   assign frame_start = dly.fs;

`ifdef ADV7123_SYNC_ON_GREEN_EN
   // Composite sync: low while exactly one of the two syncs is in its active level.
   assign sync_n = ~((dly.hs == HSYNC_POL) ^ (dly.vs == VSYNC_POL));
`else
   assign sync_n = 1'b1;
`endif

endmodule

// File: tb/tb_adv7123_vga_timing.sv
// Bench for adv7123_vga_timing: three configurations driven by shared random en/reset,
// each compared every cycle with a raster model computed from enabled-cycle count.
module tb_adv7123_vga_timing;

   typedef struct {
      int ha, hfp, hs, hb, va, vfp, vs, vb, lat;
      bit hpol, vpol;
   } cfg_t;

   typedef struct {
      logic req, de, hs, vs, sn, ls, fs;
      int   x, y;
   } exp_t;

`ifdef ADV7123_SYNC_ON_GREEN_EN
   localparam bit SOG = 1'b1;
`else
   localparam bit SOG = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic en;

   always #5 clk = ~clk;

   logic       d0_req, d0_de, d0_bl, d0_sn, d0_hs, d0_vs, d0_ls, d0_fs;
   logic [9:0] d0_x;
   logic [8:0] d0_y;
   logic       d1_req, d1_de, d1_bl, d1_sn, d1_hs, d1_vs, d1_ls, d1_fs;
   logic [4:0] d1_x;
   logic [2:0] d1_y;
   logic       d2_req, d2_de, d2_bl, d2_sn, d2_hs, d2_vs, d2_ls, d2_fs;
   logic [1:0] d2_x;
   logic [0:0] d2_y;

   adv7123_vga_timing u_d0 (
      .clk(clk), .rst(rst), .en(en), .pix_req(d0_req), .pix_x(d0_x), .pix_y(d0_y),
      .de(d0_de), .blank_n(d0_bl), .sync_n(d0_sn), .hsync(d0_hs), .vsync(d0_vs),
      .line_start(d0_ls), .frame_start(d0_fs));

   adv7123_vga_timing #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LAT(3)
   ) u_d1 (
      .clk(clk), .rst(rst), .en(en), .pix_req(d1_req), .pix_x(d1_x), .pix_y(d1_y),
      .de(d1_de), .blank_n(d1_bl), .sync_n(d1_sn), .hsync(d1_hs), .vsync(d1_vs),
      .line_start(d1_ls), .frame_start(d1_fs));

   adv7123_vga_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_LAT(0)
   ) u_d2 (
      .clk(clk), .rst(rst), .en(en), .pix_req(d2_req), .pix_x(d2_x), .pix_y(d2_y),
      .de(d2_de), .blank_n(d2_bl), .sync_n(d2_sn), .hsync(d2_hs), .vsync(d2_vs),
      .line_start(d2_ls), .frame_start(d2_fs));

   cfg_t cfg [3];
   int   k;
   int   lx [3];
   int   ly [3];
   int   n_checks;
   int   n_errors;
   int   s_cyc, s_de;
   bit   s_seen;

   function automatic bit active_at(input cfg_t c, input int q, output int x, output int y);
      int ht, vt;
      ht = c.ha + c.hfp + c.hs + c.hb;
      vt = c.va + c.vfp + c.vs + c.vb;
      x  = q % ht;
      y  = (q / ht) % vt;
      return (x < c.ha) && (y < c.va);
   endfunction

   // Expected port values after kk enabled edges since reset release.
   function automatic exp_t model(input cfg_t c, input int kk, input int px, input int py);
      exp_t e;
      int   x, y, q;
      bit   a, hact, vact;
      e.x   = px;
      e.y   = py;
      e.req = 1'b0;
      e.de  = 1'b0;
      e.ls  = 1'b0;
      e.fs  = 1'b0;
      hact  = 1'b0;
      vact  = 1'b0;
      if (kk >= 1)
         e.req = active_at(c, kk - 1, x, y);
      q = kk - 1 - c.lat;
      if (q >= 0) begin
         a    = active_at(c, q, x, y);
         e.de = a;
         e.ls = a && (x == 0);
         e.fs = a && (x == 0) && (y == 0);
         hact = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hs);
         vact = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vs);
      end
      e.hs = hact ? c.hpol : ~c.hpol;
      e.vs = vact ? c.vpol : ~c.vpol;
      e.sn = SOG ? ~(hact ^ vact) : 1'b1;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s at k=%0d t=%0t: got %0d expected %0d", tag, k, $time, obs, expv);
      end
   endtask

   task automatic check_inst(input int i, input logic req, input logic [31:0] x,
                             input logic [31:0] y, input logic de, input logic bl,
                             input logic sn, input logic hs, input logic vs,
                             input logic ls, input logic fs);
      exp_t  e;
      string p;
      e = model(cfg[i], k, lx[i], ly[i]);
      p = $sformatf("d%0d", i);
      check({p, ".pix_req"}, 32'(req), 32'(e.req));
      check({p, ".pix_x"}, x, e.x);
      check({p, ".pix_y"}, y, e.y);
      check({p, ".de"}, 32'(de), 32'(e.de));
      check({p, ".blank_n"}, 32'(bl), 32'(e.de));
      check({p, ".sync_n"}, 32'(sn), 32'(e.sn));
      check({p, ".hsync"}, 32'(hs), 32'(e.hs));
      check({p, ".vsync"}, 32'(vs), 32'(e.vs));
      check({p, ".line_start"}, 32'(ls), 32'(e.ls));
      check({p, ".frame_start"}, 32'(fs), 32'(e.fs));
   endtask

   task automatic check_all();
      check_inst(0, d0_req, 32'(d0_x), 32'(d0_y), d0_de, d0_bl, d0_sn, d0_hs, d0_vs, d0_ls, d0_fs);
      check_inst(1, d1_req, 32'(d1_x), 32'(d1_y), d1_de, d1_bl, d1_sn, d1_hs, d1_vs, d1_ls, d1_fs);
      check_inst(2, d2_req, 32'(d2_x), 32'(d2_y), d2_de, d2_bl, d2_sn, d2_hs, d2_vs, d2_ls, d2_fs);
   endtask

   task automatic step(input logic en_v);
      int  x, y;
      bit  counted;
      en = en_v;
      @(posedge clk);
      counted = !rst && en;
      if (counted) begin
         k++;
         for (int i = 0; i < 3; i++)
            if (active_at(cfg[i], k - 1, x, y)) begin
               lx[i] = x;
               ly[i] = y;
            end
      end
      #1;
      check_all();
      // Small configuration: 8x5 raster, 40 cycles and 8 data-enables per frame.
      if (counted) begin
         s_cyc++;
         if (d2_fs) begin
            if (s_seen) begin
               check("d2.frame_period", s_cyc, 40);
               check("d2.de_per_frame", s_de, 8);
            end
            s_seen = 1'b1;
            s_cyc  = 0;
            s_de   = 0;
         end
         if (d2_de)
            s_de++;
      end
   endtask

   task automatic reset_mid();
      #2;
      rst = 1'b1;
      #1;
      k      = 0;
      s_seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lx[i] = 0;
         ly[i] = 0;
      end
      check_all();
      step(1'b1);
      step(1'b1);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      cfg[0] = '{ha: 640, hfp: 16, hs: 96, hb: 48, va: 480, vfp: 10, vs: 2, vb: 33, lat: 2,
                 hpol: 1'b0, vpol: 1'b0};
      cfg[1] = '{ha: 20, hfp: 3, hs: 4, hb: 5, va: 6, vfp: 2, vs: 2, vb: 3, lat: 3,
                 hpol: 1'b1, vpol: 1'b1};
      cfg[2] = '{ha: 4, hfp: 1, hs: 2, hb: 1, va: 2, vfp: 1, vs: 1, vb: 1, lat: 0,
                 hpol: 1'b0, vpol: 1'b0};
      n_checks = 0;
      n_errors = 0;
      k        = 0;
      s_cyc    = 0;
      s_de     = 0;
      s_seen   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lx[i] = 0;
         ly[i] = 0;
      end
      rst = 1'b1;
      en  = 1'b0;
      #3;
      check_all();
      step(1'b0);
      step(1'b0);
      #2;
      rst = 1'b0;

      // Run to pixel (100,5) of the default raster, stall 37 cycles, then resume.
      repeat (4101) step(1'b1);
      check("d0.stall_x", 32'(d0_x), 100);
      check("d0.stall_y", 32'(d0_y), 5);
      repeat (37) step(1'b0);
      step(1'b1);
      check("d0.resume_x", 32'(d0_x), 101);
      check("d0.resume_y", 32'(d0_y), 5);
      repeat (1500) step(1'b1);

      reset_mid();
      repeat (6000) begin
         step($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 999) == 0)
            reset_mid();
      end
      repeat (800) step(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
